// File: rtl/rd_dma_sched.sv
// Read-DMA descriptor scheduler: queues host {base,len} descriptors
// and programs the DMA CSR port one job at a time.
module rd_dma_sched #(
  parameter int CSR_DATA_W     = 32,
  parameter int CSR_ADDR_W     = 4,
  parameter int DMA_CSR_ADDR_W = 4,
  parameter int DESC_DEPTH     = 16,
  parameter int DMA_REG_BASE   = 0,
  parameter int DMA_REG_SIZE   = 1,
  parameter int DMA_REG_RUN    = 2,
  parameter int DMA_REG_IRQ_EN = 3
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [CSR_ADDR_W-1:0]     amm_slave_csr_address_i,
  input  logic                      amm_slave_csr_read_i,
  output logic [CSR_DATA_W-1:0]     amm_slave_csr_readdata_o,
  input  logic                      amm_slave_csr_write_i,
  input  logic [CSR_DATA_W-1:0]     amm_slave_csr_writedata_i,
  output logic [DMA_CSR_ADDR_W-1:0] amm_dma_csr_address_o,
  output logic                      amm_dma_csr_write_o,
  output logic [CSR_DATA_W-1:0]     amm_dma_csr_writedata_o,
  input  logic                      dma_irq_i,
  output logic                      sched_irq_o
);

  localparam int AW = $clog2(DESC_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CSR_ADDR_W-1:0] A_BASE = CSR_ADDR_W'(0);
  localparam logic [CSR_ADDR_W-1:0] A_LEN  = CSR_ADDR_W'(1);
  localparam logic [CSR_ADDR_W-1:0] A_CTRL = CSR_ADDR_W'(2);
  localparam logic [CSR_ADDR_W-1:0] A_STAT = CSR_ADDR_W'(3);
  localparam logic [CSR_ADDR_W-1:0] A_DONE = CSR_ADDR_W'(4);

  localparam logic [DMA_CSR_ADDR_W-1:0] R_BASE = DMA_CSR_ADDR_W'(DMA_REG_BASE);
  localparam logic [DMA_CSR_ADDR_W-1:0] R_SIZE = DMA_CSR_ADDR_W'(DMA_REG_SIZE);
  localparam logic [DMA_CSR_ADDR_W-1:0] R_RUN  = DMA_CSR_ADDR_W'(DMA_REG_RUN);
  localparam logic [DMA_CSR_ADDR_W-1:0] R_IEN  = DMA_CSR_ADDR_W'(DMA_REG_IRQ_EN);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_BASE, S_WR_SIZE, S_WR_IEN,
    S_WR_RUN, S_WAIT, S_WR_IOFF
  } state_t;

  state_t                state;
  logic [CSR_DATA_W-1:0] staged_base;
  logic [CSR_DATA_W-1:0] cur_len;
  logic [CSR_DATA_W-1:0] done_cnt;
  logic                  en;
  logic                  irq_en;
  logic                  ovf;

  logic [CSR_DATA_W-1:0] q_base [DESC_DEPTH];
  logic [CSR_DATA_W-1:0] q_len  [DESC_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;

  logic wr_base, wr_len, wr_ctrl, wr_stat, wr_done;
  logic flush, push, accept, pop, full, empty, job_end;
  logic [CSR_DATA_W-1:0] rd_mux;

  assign wr_base = amm_slave_csr_write_i && amm_slave_csr_address_i == A_BASE;
  assign wr_len  = amm_slave_csr_write_i && amm_slave_csr_address_i == A_LEN;
  assign wr_ctrl = amm_slave_csr_write_i && amm_slave_csr_address_i == A_CTRL;
  assign wr_stat = amm_slave_csr_write_i && amm_slave_csr_address_i == A_STAT;
  assign wr_done = amm_slave_csr_write_i && amm_slave_csr_address_i == A_DONE;

  assign full    = cnt == CW'(DESC_DEPTH);
  assign empty   = cnt == '0;
  assign flush   = wr_ctrl && amm_slave_csr_writedata_i[2];
  assign push    = wr_len && !flush;
  assign accept  = push && !full;
  assign pop     = state == S_IDLE && en && !empty;
  assign job_end = (state == S_WR_BASE && cur_len == '0) ||
                   state == S_WR_IOFF;
  assign cnt_nxt = flush ? '0 : cnt + CW'(accept) - CW'(pop);

  always_ff @(posedge clk_i) begin
    if (accept) begin
      q_base[wr_ptr] <= staged_base;
      q_len[wr_ptr]  <= amm_slave_csr_writedata_i;
    end
  end

  // A flush may coincide with a pop; the popped head is still launched.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (accept) wr_ptr <= wr_ptr + 1'b1;
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && full) ovf <= 1'b1;
      else if (wr_stat) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      staged_base <= '0;
      en          <= 1'b0;
      irq_en      <= 1'b0;
      done_cnt    <= '0;
      sched_irq_o <= 1'b0;
    end else begin
      if (wr_base) staged_base <= amm_slave_csr_writedata_i;
      if (wr_ctrl) begin
        en     <= amm_slave_csr_writedata_i[0];
        irq_en <= amm_slave_csr_writedata_i[1];
      end
      if (wr_done)      done_cnt <= '0;
      else if (job_end) done_cnt <= done_cnt + 1'b1;
      if (wr_done || !irq_en)
        sched_irq_o <= 1'b0;
      else if (job_end && cnt_nxt == '0)
        sched_irq_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state                   <= S_IDLE;
      cur_len                 <= '0;
      amm_dma_csr_write_o     <= 1'b0;
      amm_dma_csr_address_o   <= '0;
      amm_dma_csr_writedata_o <= '0;
    end else begin
      amm_dma_csr_write_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            state                   <= S_WR_BASE;
            cur_len                 <= q_len[rd_ptr];
            amm_dma_csr_write_o     <= q_len[rd_ptr] != '0;
            amm_dma_csr_address_o   <= R_BASE;
            amm_dma_csr_writedata_o <= q_base[rd_ptr];
          end
        end
        S_WR_BASE: begin
          if (cur_len == '0) begin
            state <= S_IDLE;
          end else begin
            state                   <= S_WR_SIZE;
            amm_dma_csr_write_o     <= 1'b1;
            amm_dma_csr_address_o   <= R_SIZE;
            amm_dma_csr_writedata_o <= cur_len - 1'b1;
          end
        end
        S_WR_SIZE: begin
          state                   <= S_WR_IEN;
          amm_dma_csr_write_o     <= 1'b1;
          amm_dma_csr_address_o   <= R_IEN;
          amm_dma_csr_writedata_o <= CSR_DATA_W'(1);
        end
        S_WR_IEN: begin
          state                   <= S_WR_RUN;
          amm_dma_csr_write_o     <= 1'b1;
          amm_dma_csr_address_o   <= R_RUN;
          amm_dma_csr_writedata_o <= CSR_DATA_W'(1);
        end
        S_WR_RUN: state <= S_WAIT;
        S_WAIT: begin
          if (dma_irq_i) begin
            state                   <= S_WR_IOFF;
            amm_dma_csr_write_o     <= 1'b1;
            amm_dma_csr_address_o   <= R_IEN;
            amm_dma_csr_writedata_o <= '0;
          end
        end
        S_WR_IOFF: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (amm_slave_csr_address_i)
      A_BASE: rd_mux = staged_base;
      A_CTRL: rd_mux[1:0] = {irq_en, en};
      A_STAT: begin
        rd_mux[0]    = state != S_IDLE;
        rd_mux[1]    = full;
        rd_mux[2]    = ovf;
        rd_mux[15:8] = 8'(cnt);
      end
      A_DONE: rd_mux = done_cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                 amm_slave_csr_readdata_o <= '0;
    else if (amm_slave_csr_read_i) amm_slave_csr_readdata_o <= rd_mux;
  end

endmodule

// File: tb/tb_rd_dma_sched.sv
// Directed bench for rd_dma_sched with a small DMA responder
// and a log of every DMA CSR write.
module tb_rd_dma_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  h_addr = '0;
  logic        h_rd = 1'b0;
  logic        h_wr = 1'b0;
  logic [31:0] h_wdata = '0;
  logic [31:0] h_rdata;
  logic [3:0]  d_addr;
  logic        d_wr;
  logic [31:0] d_wdata;
  logic        dma_irq;
  logic        irq_auto = 1'b0;
  logic        irq_man = 1'b0;
  logic        auto_dma = 1'b1;
  logic        s_irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 0;
  logic [31:0] rv;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;
  wr_t wlog[$];

  assign dma_irq = irq_auto | irq_man;

  always #5 clk = ~clk;

  rd_dma_sched dut (
    .clk_i                     (clk),
    .arst_n_i                  (rst_n),
    .amm_slave_csr_address_i   (h_addr),
    .amm_slave_csr_read_i      (h_rd),
    .amm_slave_csr_readdata_o  (h_rdata),
    .amm_slave_csr_write_i     (h_wr),
    .amm_slave_csr_writedata_i (h_wdata),
    .amm_dma_csr_address_o     (d_addr),
    .amm_dma_csr_write_o       (d_wr),
    .amm_dma_csr_writedata_o   (d_wdata),
    .dma_irq_i                 (dma_irq),
    .sched_irq_o               (s_irq)
  );

  // DMA model: raises its IRQ 4 cycles after RUN, drops it on IEN=0.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (lat > 0) begin
      lat--;
      if (lat == 0) irq_auto = 1'b1;
    end
    if (d_wr) begin
      wlog.push_back('{a: d_addr, d: d_wdata, c: cyc});
      if (d_addr == 4'd2 && d_wdata == 32'd1 && auto_dma) lat = 4;
      if (d_addr == 4'd3 && d_wdata == 32'd0) irq_auto = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic hw(input logic [3:0] a, input logic [31:0] d);
    h_addr = a;
    h_wdata = d;
    h_wr = 1'b1;
    @(negedge clk);
    h_wr = 1'b0;
  endtask

  task automatic hr(input logic [3:0] a, output logic [31:0] d);
    h_addr = a;
    h_rd = 1'b1;
    @(negedge clk);
    h_rd = 1'b0;
    d = h_rdata;
  endtask

  task automatic push(input logic [31:0] b, input logic [31:0] l);
    hw(4'd0, b);
    hw(4'd1, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_wr(input int n, input string tag);
    int b;
    b = 0;
    while (wlog.size() < n && b < 300) begin
      @(negedge clk);
      b++;
    end
    chk(tag, 32'(wlog.size() >= n), 32'd1);
  endtask

  task automatic chk_job(input int i, input logic [31:0] b,
                         input logic [31:0] sz, input string tag);
    if (wlog.size() < i + 5) begin
      chk({tag, "_len"}, 32'(wlog.size()), 32'(i + 5));
    end else begin
      chk({tag, "_a0"}, {28'd0, wlog[i].a}, 32'd0);
      chk({tag, "_d0"}, wlog[i].d, b);
      chk({tag, "_a1"}, {28'd0, wlog[i+1].a}, 32'd1);
      chk({tag, "_d1"}, wlog[i+1].d, sz);
      chk({tag, "_ien"}, {wlog[i+2].a, wlog[i+2].d[27:0]}, {4'd3, 28'd1});
      chk({tag, "_run"}, {wlog[i+3].a, wlog[i+3].d[27:0]}, {4'd2, 28'd1});
      chk({tag, "_off"}, {wlog[i+4].a, wlog[i+4].d[27:0]}, {4'd3, 28'd0});
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_dwr", {31'd0, d_wr}, 32'd0);
    chk("rst_daddr", {28'd0, d_addr}, 32'd0);
    chk("rst_irq", {31'd0, s_irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    hr(4'd3, rv); chk("rst_status", rv, 32'd0);
    hr(4'd4, rv); chk("rst_done", rv, 32'd0);

    // 1: single job
    push(32'h100, 32'd8);
    wlog.delete();
    hw(4'd2, 32'd3);
    wait_wr(5, "t1_wait");
    chk_job(0, 32'h100, 32'd7, "t1");
    if (wlog.size() >= 5) begin
      chk("t1_gap1", 32'(wlog[1].c - wlog[0].c), 32'd1);
      chk("t1_gap3", 32'(wlog[3].c - wlog[0].c), 32'd3);
      chk("t1_off_lat", 32'(wlog[4].c - wlog[3].c), 32'd5);
    end
    idle(3);
    hr(4'd4, rv); chk("t1_done", rv, 32'd1);
    chk("t1_sirq", {31'd0, s_irq}, 32'd1);
    hr(4'd3, rv); chk("t1_busy", rv, 32'd0);
    hw(4'd4, 32'd0);
    @(negedge clk);
    hr(4'd4, rv); chk("t1_done_clr", rv, 32'd0);
    chk("t1_sirq_clr", {31'd0, s_irq}, 32'd0);

    // 2: three jobs back-to-back
    hw(4'd2, 32'd2);
    push(32'h200, 32'd4);
    push(32'h300, 32'd2);
    push(32'h400, 32'd16);
    wlog.delete();
    hw(4'd2, 32'd3);
    wait_wr(15, "t2_wait");
    chk_job(0, 32'h200, 32'd3, "t2j0");
    chk_job(5, 32'h300, 32'd1, "t2j1");
    chk_job(10, 32'h400, 32'd15, "t2j2");
    if (wlog.size() >= 15) begin
      chk("t2_gap1", 32'(wlog[5].c - wlog[4].c), 32'd2);
      chk("t2_gap2", 32'(wlog[10].c - wlog[9].c), 32'd2);
    end
    idle(3);
    hr(4'd4, rv); chk("t2_done", rv, 32'd3);
    chk("t2_sirq", {31'd0, s_irq}, 32'd1);

    // 3: overflow and flush
    hw(4'd2, 32'd0);
    hw(4'd4, 32'd0);
    for (int i = 0; i < 17; i++) push(32'h1000 + 32'(i), 32'd1);
    hr(4'd3, rv); chk("t3_full", rv, 32'h1006);
    hw(4'd3, 32'd0);
    hr(4'd3, rv); chk("t3_ovf_clr", rv, 32'h1002);
    wlog.delete();
    hw(4'd2, 32'd4);
    hr(4'd3, rv); chk("t3_flush", rv, 32'd0);
    hr(4'd2, rv); chk("t3_ctrl", rv, 32'd0);
    hw(4'd2, 32'd1);
    idle(10);
    chk("t3_nowr", 32'(wlog.size()), 32'd0);
    hr(4'd4, rv); chk("t3_done", rv, 32'd0);

    // 4: zero-length descriptor
    hw(4'd2, 32'd0);
    push(32'h50, 32'd0);
    push(32'h40, 32'd1);
    wlog.delete();
    hw(4'd2, 32'd1);
    wait_wr(5, "t4_wait");
    chk_job(0, 32'h40, 32'd0, "t4");
    idle(3);
    chk("t4_cnt", 32'(wlog.size()), 32'd5);
    hr(4'd4, rv); chk("t4_done", rv, 32'd2);
    chk("t4_sirq", {31'd0, s_irq}, 32'd0);

    // 5: enable dropped during WAIT
    hw(4'd2, 32'd0);
    hw(4'd4, 32'd0);
    push(32'h500, 32'd2);
    push(32'h600, 32'd3);
    push(32'h700, 32'd4);
    auto_dma = 1'b0;
    wlog.delete();
    hw(4'd2, 32'd1);
    wait_wr(4, "t5_wait_run");
    idle(2);
    hw(4'd2, 32'd0);
    irq_man = 1'b1;
    wait_wr(5, "t5_wait_off");
    irq_man = 1'b0;
    idle(10);
    chk("t5_hold", 32'(wlog.size()), 32'd5);
    hr(4'd3, rv); chk("t5_level", rv, 32'h0200);
    hr(4'd4, rv); chk("t5_done1", rv, 32'd1);
    auto_dma = 1'b1;
    hw(4'd2, 32'd1);
    wait_wr(15, "t5_wait_all");
    chk_job(0, 32'h500, 32'd1, "t5j0");
    chk_job(5, 32'h600, 32'd2, "t5j1");
    chk_job(10, 32'h700, 32'd3, "t5j2");
    idle(3);
    hr(4'd4, rv); chk("t5_done3", rv, 32'd3);
    hr(4'd3, rv); chk("t5_empty", rv, 32'd0);

    // 6: reset while waiting for the DMA
    hw(4'd2, 32'd2);
    auto_dma = 1'b0;
    push(32'h800, 32'd2);
    push(32'h900, 32'd3);
    wlog.delete();
    hw(4'd2, 32'd3);
    wait_wr(4, "t6_wait_run");
    idle(2);
    hr(4'd3, rv); chk("t6_busy", rv, 32'h0101);
    rst_n = 1'b0;
    #1;
    chk("t6_dwr", {31'd0, d_wr}, 32'd0);
    chk("t6_daddr", {28'd0, d_addr}, 32'd0);
    chk("t6_ddata", d_wdata, 32'd0);
    chk("t6_rdata", h_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wlog.delete();
    irq_man = 1'b1;
    idle(6);
    chk("t6_irq_ign", 32'(wlog.size()), 32'd0);
    hr(4'd3, rv); chk("t6_status", rv, 32'd0);
    hr(4'd2, rv); chk("t6_ctrl", rv, 32'd0);
    irq_man = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
